load_store_unit: RTL and testbench

//  Sits between the pipeline MEM stage and the byte-addressed, big-endian data memory (as_/rw/addr/wr_data/rd_data port).

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into whole-word
// accesses on a big-endian memory, with read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int   ADDR_W = 30,
    parameter logic READ   = 1'b1,
    parameter logic WRITE  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] memory_addr,
    output logic              memory_as_,
    output logic              memory_rw,
    output logic [31:0]       memory_wr_data,
    input  logic [31:0]       memory_rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              req_bad;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

    // Misalignment / illegal size check on the incoming request
    always_comb begin
        req_bad = 1'b0;
        unique case (req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = |req_addr[1:0];
            default: req_bad = 1'b1;
        endcase
    end

    // Big-endian lane extraction and sign/zero extension of load data
    always_comb begin
        lane_b = memory_rd_data[31:24];
        unique case (addr_q[1:0])
            2'd0:    lane_b = memory_rd_data[31:24];
            2'd1:    lane_b = memory_rd_data[23:16];
            2'd2:    lane_b = memory_rd_data[15:8];
            default: lane_b = memory_rd_data[7:0];
        endcase
        lane_h = addr_q[1] ? memory_rd_data[15:0] : memory_rd_data[31:16];
        if (size_q == 2'b00) begin
            load_val = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
        end else if (size_q == 2'b01) begin
            load_val = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
        end else begin
            load_val = memory_rd_data;
        end
    end

    // Replace the target lane of the read word with the store data
    always_comb begin
        merge_val = memory_rd_data;
        if (size_q == 2'b00) begin
            unique case (addr_q[1:0])
                2'd0:    merge_val[31:24] = wdata_q[7:0];
                2'd1:    merge_val[23:16] = wdata_q[7:0];
                2'd2:    merge_val[15:8]  = wdata_q[7:0];
                default: merge_val[7:0]   = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_val[15:0] = wdata_q;
        end else begin
            merge_val[31:16] = wdata_q;
        end
    end

    // Next-state selection and outputs decoded from the registered state
    always_comb begin
        state_nxt      = state;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        memory_as_     = 1'b1;
        memory_rw      = READ;
        memory_wr_data = 32'd0;
        memory_addr    = {addr_q[ADDR_W-1:2], 2'b00};
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)                state_nxt = RESP;
                    else if (!req_we)           state_nxt = LOAD;
                    else if (req_size == 2'b10) state_nxt = WR;
                    else                        state_nxt = RMW_RD;
                end
            end
            LOAD: begin
                memory_as_ = 1'b0;
                state_nxt  = RESP;
            end
            RMW_RD: begin
                memory_as_ = 1'b0;
                state_nxt  = WR;
            end
            WR: begin
                memory_as_     = 1'b0;
                memory_rw      = WRITE;
                memory_wr_data = merge_q;
                state_nxt      = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset forces IDLE so the strobe drops at once
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= IDLE;
        else       state <= state_nxt;
    end

    // Request capture, load result and merge word registers
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 16'd0;
            merge_q   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                size_q    <= req_size;
                uns_q     <= req_unsigned;
                addr_q    <= req_addr;
                wdata_q   <= req_wdata[15:0];
                merge_q   <= req_wdata;
                rsp_rdata <= 32'd0;
                rsp_err   <= req_bad;
            end
            if (state == LOAD)   rsp_rdata <= load_val;
            if (state == RMW_RD) merge_q   <= merge_val;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model of a
// big-endian memory, directed scenarios plus randomized traffic.
module tb_load_store_unit;

    localparam int ADDR_W = 30;

    logic              clk = 1'b0;
    logic              rst_;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] memory_addr;
    logic              memory_as_;
    logic              memory_rw;
    logic [31:0]       memory_wr_data;
    logic [31:0]       memory_rd_data;

    load_store_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .memory_addr(memory_addr), .memory_as_(memory_as_),
        .memory_rw(memory_rw), .memory_wr_data(memory_wr_data),
        .memory_rd_data(memory_rd_data)
    );

    always #5 clk = ~clk;

    // Word memory seen by the DUT (256 bytes)
    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_data = 32'd0;

    assign memory_rd_data = mem[memory_addr[7:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (!memory_as_ && memory_rw == 1'b0)
            mem[memory_addr[7:2]] <= memory_wr_data;
    end

    // Reference model: plain byte array, index 0 is the most significant byte
    logic [7:0] ref_b [0:255];
    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          we;
        logic [1:0]  s;
        bit          u;
        logic [7:0]  a;
        logic [31:0] wd;
    } req_t;

    function automatic bit ref_err(input logic [1:0] s, input logic [7:0] a);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] s, input bit u,
                                             input logic [7:0] a);
        int i;
        logic [31:0] v;
        i = int'(a);
        if (s == 2'd0) begin
            v = {24'd0, ref_b[i]};
            if (!u && ref_b[i][7]) v = v - 32'd256;
        end else if (s == 2'd1) begin
            v = {16'd0, ref_b[i], ref_b[i+1]};
            if (!u && ref_b[i][7]) v = v - 32'd65536;
        end else begin
            v = {ref_b[i], ref_b[i+1], ref_b[i+2], ref_b[i+3]};
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] s, input logic [7:0] a,
                             input logic [31:0] wd);
        int i;
        i = int'(a);
        if (s == 2'd0) begin
            ref_b[i] = wd[7:0];
        end else if (s == 2'd1) begin
            ref_b[i] = wd[15:8]; ref_b[i+1] = wd[7:0];
        end else begin
            ref_b[i] = wd[31:24]; ref_b[i+1] = wd[23:16];
            ref_b[i+2] = wd[15:8]; ref_b[i+3] = wd[7:0];
        end
    endtask

    function automatic int ref_lat(input bit we, input logic [1:0] s,
                                   input logic [7:0] a);
        if (ref_err(s, a)) return 1;
        if (!we || s == 2'd2) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w], ref_b[4*w+1], ref_b[4*w+2], ref_b[4*w+3]};
    endfunction

    task automatic preload(input int w, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = 6'(w); pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
        ref_b[4*w] = d[31:24]; ref_b[4*w+1] = d[23:16];
        ref_b[4*w+2] = d[15:8]; ref_b[4*w+3] = d[7:0];
    endtask

    task automatic drive(input req_t r);
        req_we = r.we; req_size = r.s; req_unsigned = r.u;
        req_addr = {22'd0, r.a}; req_wdata = r.wd;
    endtask

    // One transaction: returns result, latency and memory activity seen
    task automatic run_req(input req_t r, output logic [31:0] rd,
                           output logic er, output int lat, output int as_cnt,
                           output int wr_cnt, output bit pulse_one);
        int guard;
        @(negedge clk);
        drive(r);
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; as_cnt = 0; wr_cnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!memory_as_) as_cnt++;
            if (!memory_as_ && memory_rw == 1'b0) wr_cnt++;
        end while (!rsp_valid && lat < 10);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        pulse_one = !rsp_valid;
    endtask

    task automatic test_reset();
        rst_ = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'd0;
        #12;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_err, memory_as_, memory_rw} !== 5'b10011) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 10011",
                     {req_ready, rsp_valid, rsp_err, memory_as_, memory_rw});
        end
        n_tests++;
        if (rsp_rdata !== 32'd0 || memory_wr_data !== 32'd0 || memory_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h wr=%h addr=%h want 0",
                     rsp_rdata, memory_wr_data, memory_addr);
        end
        @(negedge clk);
        rst_ = 1'b1;
        for (int w = 0; w < 64; w++) preload(w, 32'd0);
    endtask

    task automatic test_word();
        req_t r;
        logic [31:0] rd; logic er; int lat, ac, wc; bit p1;
        r = '{we: 1'b1, s: 2'd2, u: 1'b0, a: 8'h10, wd: 32'hDEADBEEF};
        run_req(r, rd, er, lat, ac, wc, p1);
        ref_store(r.s, r.a, r.wd);
        n_tests++;
        if (lat !== 2 || wc !== 1 || er !== 1'b0 || !p1) begin
            n_fail++;
            $display("FAIL word_store: lat=%0d wr=%0d err=%b pulse1=%0d want 2 1 0 1",
                     lat, wc, er, p1);
        end
        n_tests++;
        if (mem[4] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_store_mem: got %h want deadbeef", mem[4]);
        end
        r = '{we: 1'b0, s: 2'd2, u: 1'b0, a: 8'h10, wd: 32'd0};
        run_req(r, rd, er, lat, ac, wc, p1);
        n_tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2 || !p1) begin
            n_fail++;
            $display("FAIL word_load: got %h err=%b lat=%0d want deadbeef 0 2",
                     rd, er, lat);
        end
    endtask

    task automatic test_byte_rmw();
        req_t r;
        logic [31:0] rd; logic er; int lat, ac, wc; bit p1;
        preload(4, 32'h11223344);
        r = '{we: 1'b1, s: 2'd0, u: 1'b0, a: 8'h11, wd: 32'h000000AA};
        run_req(r, rd, er, lat, ac, wc, p1);
        ref_store(r.s, r.a, r.wd);
        n_tests++;
        if (lat !== 3 || ac !== 2 || wc !== 1 || !p1) begin
            n_fail++;
            $display("FAIL byte_rmw_seq: lat=%0d as=%0d wr=%0d want 3 2 1",
                     lat, ac, wc);
        end
        n_tests++;
        if (mem[4] !== 32'h11AA3344) begin
            n_fail++;
            $display("FAIL byte_rmw_mem: got %h want 11aa3344", mem[4]);
        end
    endtask

    task automatic test_loads();
        req_t r;
        logic [31:0] rd; logic er; int lat, ac, wc; bit p1;
        logic [31:0] want [3];
        req_t rs [3];
        want[0] = 32'hFFFFFF80; want[1] = 32'h00000080; want[2] = 32'h00007F01;
        rs[0] = '{we: 1'b0, s: 2'd0, u: 1'b0, a: 8'h20, wd: 32'd0};
        rs[1] = '{we: 1'b0, s: 2'd0, u: 1'b1, a: 8'h20, wd: 32'd0};
        rs[2] = '{we: 1'b0, s: 2'd1, u: 1'b0, a: 8'h22, wd: 32'd0};
        preload(8, 32'h80FF7F01);
        for (int k = 0; k < 3; k++) begin
            r = rs[k];
            run_req(r, rd, er, lat, ac, wc, p1);
            n_tests++;
            if (rd !== want[k] || rd !== ref_load(r.s, r.u, r.a) || er !== 1'b0) begin
                n_fail++;
                $display("FAIL load_ext%0d: got %h err=%b want %h", k, rd, er, want[k]);
            end
        end
    endtask

    task automatic test_errors();
        req_t r;
        logic [31:0] rd; logic er; int lat, ac, wc; bit p1;
        req_t rs [3];
        rs[0] = '{we: 1'b0, s: 2'd1, u: 1'b0, a: 8'h21, wd: 32'd0};
        rs[1] = '{we: 1'b1, s: 2'd2, u: 1'b0, a: 8'h22, wd: 32'h12345678};
        rs[2] = '{we: 1'b1, s: 2'd3, u: 1'b0, a: 8'h24, wd: 32'hCAFEF00D};
        for (int k = 0; k < 3; k++) begin
            r = rs[k];
            run_req(r, rd, er, lat, ac, wc, p1);
            n_tests++;
            if (er !== 1'b1 || lat !== 1 || ac !== 0 || rd !== 32'd0 || !p1) begin
                n_fail++;
                $display("FAIL err%0d: err=%b lat=%0d as=%0d rd=%h want 1 1 0 0",
                         k, er, lat, ac, rd);
            end
        end
        n_tests++;
        if (mem[8] !== ref_word(8) || mem[9] !== ref_word(9)) begin
            n_fail++;
            $display("FAIL err_mem: got %h %h want %h %h",
                     mem[8], mem[9], ref_word(8), ref_word(9));
        end
    endtask

    task automatic test_reset_mid_wr();
        req_t r;
        int guard, seen;
        preload(12, 32'h55667788);
        r = '{we: 1'b1, s: 2'd0, u: 1'b0, a: 8'h31, wd: 32'h000000EE};
        @(negedge clk);
        drive(r);
        req_valid = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (memory_as_ !== 1'b0 || memory_rw !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wr_phase: as_=%b rw=%b want 0 0", memory_as_, memory_rw);
        end
        #1 rst_ = 1'b0;
        #1;
        n_tests++;
        if (memory_as_ !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: as_=%b rsp_valid=%b want 1 0", memory_as_, rsp_valid);
        end
        @(negedge clk);
        rst_ = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        n_tests++;
        if (seen !== 0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_after: rsp_pulses=%0d ready=%b want 0 1", seen, req_ready);
        end
        n_tests++;
        if (mem[12] !== 32'h55667788) begin
            n_fail++;
            $display("FAIL rst_mem: got %h want 55667788", mem[12]);
        end
    endtask

    task automatic test_back_to_back();
        req_t q [3];
        logic [31:0] exp_d [3];
        bit exp_e [3];
        int exp_l [3];
        int acc_c [3];
        int cyc, nresp, idx, last_resp;
        bit acc;
        q[0] = '{we: 1'b1, s: 2'd2, u: 1'b0, a: 8'h40, wd: 32'h8234F678};
        q[1] = '{we: 1'b0, s: 2'd0, u: 1'b0, a: 8'h40, wd: 32'd0};
        q[2] = '{we: 1'b0, s: 2'd1, u: 1'b1, a: 8'h42, wd: 32'd0};
        for (int k = 0; k < 3; k++) begin
            exp_e[k] = ref_err(q[k].s, q[k].a);
            exp_l[k] = ref_lat(q[k].we, q[k].s, q[k].a);
            exp_d[k] = (!q[k].we && !exp_e[k]) ? ref_load(q[k].s, q[k].u, q[k].a) : 32'd0;
            if (q[k].we && !exp_e[k]) ref_store(q[k].s, q[k].a, q[k].wd);
        end
        cyc = 0; nresp = 0; idx = 0; last_resp = -100;
        for (int k = 0; k < 3; k++) acc_c[k] = -100;
        @(negedge clk);
        drive(q[0]);
        req_valid = 1'b1;
        while (nresp < 3 && cyc < 60) begin
            if (rsp_valid) begin
                n_tests++;
                if (rsp_rdata !== exp_d[nresp] || rsp_err !== exp_e[nresp] ||
                    cyc !== acc_c[nresp] + exp_l[nresp]) begin
                    n_fail++;
                    $display("FAIL b2b_rsp%0d: data=%h err=%b cyc=%0d want %h %b %0d",
                             nresp, rsp_rdata, rsp_err, cyc, exp_d[nresp],
                             exp_e[nresp], acc_c[nresp] + exp_l[nresp]);
                end
                nresp++;
                last_resp = cyc;
            end
            acc = req_valid && req_ready;
            if (acc) begin
                acc_c[idx] = cyc;
                if (idx > 0) begin
                    n_tests++;
                    if (cyc !== last_resp + 1) begin
                        n_fail++;
                        $display("FAIL b2b_accept%0d: cyc=%0d want %0d",
                                 idx, cyc, last_resp + 1);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx < 3) drive(q[idx]);
                else req_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = 1'b0;
        n_tests++;
        if (nresp !== 3 || idx !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: responses=%0d accepts=%0d want 3 3", nresp, idx);
        end
    endtask

    task automatic test_random();
        req_t r;
        logic [31:0] rd, ed; logic er; bit ee; int lat, ac, wc, el, eac; bit p1;
        for (int n = 0; n < 40; n++) begin
            r.we = 1'($urandom_range(0, 1));
            r.s  = 2'($urandom_range(0, 3));
            r.u  = 1'($urandom_range(0, 1));
            r.a  = 8'($urandom_range(0, 255));
            r.wd = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (r.s == 2'd1) r.a[0] = 1'b0;
                if (r.s == 2'd2) r.a[1:0] = 2'b00;
            end
            ee  = ref_err(r.s, r.a);
            el  = ref_lat(r.we, r.s, r.a);
            ed  = (!r.we && !ee) ? ref_load(r.s, r.u, r.a) : 32'd0;
            eac = ee ? 0 : (el == 3 ? 2 : 1);
            run_req(r, rd, er, lat, ac, wc, p1);
            if (r.we && !ee) ref_store(r.s, r.a, r.wd);
            n_tests++;
            if (rd !== ed || er !== ee || lat !== el || ac !== eac ||
                wc !== ((r.we && !ee) ? 1 : 0) || !p1) begin
                n_fail++;
                $display("FAIL rand%0d: we=%b sz=%0d a=%h rd=%h err=%b lat=%0d as=%0d want %h %b %0d %0d",
                         n, r.we, r.s, r.a, rd, er, lat, ac, ed, ee, el, eac);
            end
        end
        for (int w = 0; w < 64; w++) begin
            n_tests++;
            if (mem[w] !== ref_word(w)) begin
                n_fail++;
                $display("FAIL rand_mem%0d: got %h want %h", w, mem[w], ref_word(w));
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_rmw();
        test_loads();
        test_errors();
        test_reset_mid_wr();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
